// File: rtl/peripheral_spram_1r1w_pipe.sv
// Simple-dual-port RAM with one write port with lane enables and one read port.
// The read latency is 1 or 2 cycles, and the array is optionally zeroed after reset.
module peripheral_spram_1r1w_pipe #(
    parameter int ABITS   = 10,
    parameter int DBITS   = 32,
    parameter int LBITS   = 8,
    parameter int LATENCY = 1,
    parameter int BYPASS  = 1,
    parameter int CLEAR   = 1,
    localparam int NLANES = (DBITS + LBITS - 1) / LBITS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              busy_o,
    input  logic [ABITS-1:0]  waddr_i,
    input  logic [DBITS-1:0]  din_i,
    input  logic              we_i,
    input  logic [NLANES-1:0] be_i,
    input  logic [ABITS-1:0]  raddr_i,
    input  logic              re_i,
    output logic [DBITS-1:0]  dout_o,
    output logic              rvalid_o
);

    localparam int DEPTH = 1 << ABITS;

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("peripheral_spram_1r1w_pipe: LATENCY must be 1 or 2");
    end
    if (LBITS < 1) begin : g_bad_lbits
        $error("peripheral_spram_1r1w_pipe: LBITS must be at least 1");
    end

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ABITS-1:0] cnt_q;
    logic [DBITS-1:0] mem [DEPTH];

    logic [DBITS-1:0] wmask;
    logic [DBITS-1:0] mem_rd;
    logic [DBITS-1:0] rd_word;
    logic             we_acc, rd_acc, clr_we, collide;
    logic [DBITS-1:0] dout_q;
    logic             rvalid_q;

    // FSM: INIT walks the clear counter over every address, READY serves traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= (CLEAR != 0) ? ST_INIT : ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (&cnt_q) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + ABITS'(1);
        end
    end

    assign busy_o  = (state_q == ST_INIT) || ((CLEAR != 0) && rst_i);
    assign clr_we  = !rst_i && (state_q == ST_INIT);
    assign we_acc  = !rst_i && (state_q == ST_READY) && we_i;
    assign rd_acc  = !rst_i && (state_q == ST_READY) && re_i;
    assign collide = we_acc && (waddr_i == raddr_i);

    // Per-bit lane mask; the top lane naturally stops at DBITS-1.
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DBITS; b++) begin
            wmask[b] = be_i[b / LBITS];
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (we_acc) begin
            mem[waddr_i] <= (mem[waddr_i] & ~wmask) | (din_i & wmask);
        end
    end

    // Same-cycle collision: merge the enabled lanes of din_i over the old word.
    always_comb begin
        mem_rd  = mem[raddr_i];
        rd_word = mem_rd;
        if ((BYPASS != 0) && collide) begin
            rd_word = (mem_rd & ~wmask) | (din_i & wmask);
        end
    end

    if (LATENCY == 2) begin : g_lat2
        logic [DBITS-1:0] d1_q;
        logic             v1_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                d1_q     <= '0;
                v1_q     <= 1'b0;
                dout_q   <= '0;
                rvalid_q <= 1'b0;
            end else begin
                v1_q     <= rd_acc;
                rvalid_q <= v1_q;
                if (rd_acc) d1_q <= rd_word;
                if (v1_q) dout_q <= d1_q;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dout_q   <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) dout_q <= rd_word;
            end
        end
    end

    assign dout_o   = dout_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_peripheral_spram_1r1w_pipe.sv
// Directed bench for peripheral_spram_1r1w_pipe covering the clear sequence, lane writes,
// collisions with both bypass settings, two-cycle latency, narrow words and reset mid-clear.
module tb_peripheral_spram_1r1w_pipe;

    logic        clk;
    logic        rst;
    logic        we, re;
    logic [3:0]  waddr, raddr;
    logic [31:0] din;
    logic [3:0]  be;
    logic [19:0] din_d;
    logic [2:0]  be_d;

    logic        busy_a, busy_b, busy_c, busy_d, busy_e;
    logic        rvalid_a, rvalid_b, rvalid_c, rvalid_d, rvalid_e;
    logic [31:0] dout_a, dout_b, dout_c, dout_e;
    logic [19:0] dout_d;

    int checks = 0;
    int passed = 0;

    // a: LATENCY=1 BYPASS=1, b: BYPASS=0, c: LATENCY=2, d: 20-bit words, e: CLEAR=0
    peripheral_spram_1r1w_pipe #(.ABITS(4), .DBITS(32), .LBITS(8), .LATENCY(1), .BYPASS(1), .CLEAR(1)) u_a (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_a), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_a), .rvalid_o(rvalid_a));
    peripheral_spram_1r1w_pipe #(.ABITS(4), .DBITS(32), .LBITS(8), .LATENCY(1), .BYPASS(0), .CLEAR(1)) u_b (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_b), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_b), .rvalid_o(rvalid_b));
    peripheral_spram_1r1w_pipe #(.ABITS(4), .DBITS(32), .LBITS(8), .LATENCY(2), .BYPASS(1), .CLEAR(1)) u_c (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_c), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_c), .rvalid_o(rvalid_c));
    peripheral_spram_1r1w_pipe #(.ABITS(4), .DBITS(20), .LBITS(8), .LATENCY(1), .BYPASS(1), .CLEAR(1)) u_d (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_d), .waddr_i(waddr), .din_i(din_d), .we_i(we), .be_i(be_d),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_d), .rvalid_o(rvalid_d));
    peripheral_spram_1r1w_pipe #(.ABITS(4), .DBITS(32), .LBITS(8), .LATENCY(1), .BYPASS(1), .CLEAR(0)) u_e (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_e), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_e), .rvalid_o(rvalid_e));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1; waddr = a; din = d; be = b;
        tick();
        we = 1'b0; be = 4'h0;
    endtask

    task automatic do_read(input logic [3:0] a);
        re = 1'b1; raddr = a;
        tick();
        re = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; re = 1'b1; waddr = 4'd0; raddr = 4'd0;
        din = 32'hFFFF_FFFF; be = 4'hF; din_d = '0; be_d = '0;
        repeat (3) tick();
        checks++; if (busy_a !== 1'b1) $display("FAIL rst_busy_a got=%b exp=1", busy_a); else passed++;
        checks++; if (busy_e !== 1'b0) $display("FAIL rst_busy_e got=%b exp=0", busy_e); else passed++;
        checks++; if (rvalid_a !== 1'b0 || rvalid_e !== 1'b0) $display("FAIL rst_rvalid got=%b%b exp=00", rvalid_a, rvalid_e); else passed++;
        checks++; if (dout_a !== 32'h0 || dout_c !== 32'h0) $display("FAIL rst_dout got=%h/%h exp=0", dout_a, dout_c); else passed++;
        we = 1'b0; re = 1'b0; be = 4'h0;
    endtask

    task automatic test_clear();
        int  n;
        logic rv_seen;
        rst = 1'b0;
        checks++; if (busy_e !== 1'b0) $display("FAIL clr0_busy got=%b exp=0", busy_e); else passed++;
        // u_e is usable at once while u_a is still clearing
        we = 1'b1; waddr = 4'd2; din = 32'h0BAD_F00D; be = 4'hF;
        n = 0; rv_seen = 1'b0;
        while (busy_a && n < 100) begin
            if (n == 1) begin we = 1'b0; be = 4'h0; re = 1'b1; raddr = 4'd2; end
            if (n == 2) begin
                re = 1'b0;
                checks++;
                if (rvalid_e !== 1'b1 || dout_e !== 32'h0BAD_F00D)
                    $display("FAIL clr0_rd got=%b/%h exp=1/0badf00d", rvalid_e, dout_e);
                else passed++;
            end
            if (rvalid_a) rv_seen = 1'b1;
            n++;
            tick();
        end
        checks++; if (n !== 16) $display("FAIL clr_busy_cycles got=%0d exp=16", n); else passed++;
        checks++; if (rv_seen !== 1'b0) $display("FAIL clr_rvalid_in_init got=%b exp=0", rv_seen); else passed++;
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i));
            checks++;
            if (rvalid_a !== 1'b1 || dout_a !== 32'h0)
                $display("FAIL clr_rd[%0d] got=%b/%h exp=1/00000000", i, rvalid_a, dout_a);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        do_write(4'd3, 32'hDEAD_BEEF, 4'hF);
        do_read(4'd3);
        checks++; if (rvalid_a !== 1'b1 || dout_a !== 32'hDEAD_BEEF) $display("FAIL wr_rd_a got=%b/%h exp=1/deadbeef", rvalid_a, dout_a); else passed++;
        checks++; if (rvalid_c !== 1'b0) $display("FAIL wr_rd_c_early got=%b exp=0", rvalid_c); else passed++;
        tick();
        checks++; if (rvalid_a !== 1'b0 || dout_a !== 32'hDEAD_BEEF) $display("FAIL hold_a got=%b/%h exp=0/deadbeef", rvalid_a, dout_a); else passed++;
        checks++; if (rvalid_c !== 1'b1 || dout_c !== 32'hDEAD_BEEF) $display("FAIL wr_rd_c got=%b/%h exp=1/deadbeef", rvalid_c, dout_c); else passed++;
    endtask

    task automatic test_bypass();
        do_write(4'd5, 32'h1122_3344, 4'hF);
        we = 1'b1; waddr = 4'd5; din = 32'hAABB_CCDD; be = 4'b0101;
        re = 1'b1; raddr = 4'd5;
        tick();
        we = 1'b0; re = 1'b0; be = 4'h0;
        checks++; if (rvalid_a !== 1'b1 || dout_a !== 32'h11BB_33DD) $display("FAIL byp1 got=%b/%h exp=1/11bb33dd", rvalid_a, dout_a); else passed++;
        checks++; if (rvalid_b !== 1'b1 || dout_b !== 32'h1122_3344) $display("FAIL byp0 got=%b/%h exp=1/11223344", rvalid_b, dout_b); else passed++;
        tick();
        checks++; if (rvalid_c !== 1'b1 || dout_c !== 32'h11BB_33DD) $display("FAIL byp1_lat2 got=%b/%h exp=1/11bb33dd", rvalid_c, dout_c); else passed++;
        do_read(4'd5);
        checks++; if (dout_b !== 32'h11BB_33DD) $display("FAIL byp0_after got=%h exp=11bb33dd", dout_b); else passed++;
    endtask

    task automatic test_be_zero();
        do_write(4'd5, 32'h0000_0000, 4'h0);
        do_read(4'd5);
        checks++; if (dout_a !== 32'h11BB_33DD) $display("FAIL be_zero got=%h exp=11bb33dd", dout_a); else passed++;
    endtask

    task automatic test_back_to_back();
        do_write(4'd1, 32'hA1A1_A1A1, 4'hF);
        do_write(4'd2, 32'hB2B2_B2B2, 4'hF);
        do_write(4'd3, 32'hC3C3_C3C3, 4'hF);
        re = 1'b1; raddr = 4'd1;
        tick();
        checks++; if (rvalid_c !== 1'b0) $display("FAIL b2b_lat got=%b exp=0", rvalid_c); else passed++;
        raddr = 4'd2;
        tick();
        checks++; if (rvalid_c !== 1'b1 || dout_c !== 32'hA1A1_A1A1) $display("FAIL b2b_0 got=%b/%h exp=1/a1a1a1a1", rvalid_c, dout_c); else passed++;
        raddr = 4'd3;
        tick();
        checks++; if (rvalid_c !== 1'b1 || dout_c !== 32'hB2B2_B2B2) $display("FAIL b2b_1 got=%b/%h exp=1/b2b2b2b2", rvalid_c, dout_c); else passed++;
        re = 1'b0;
        tick();
        checks++; if (rvalid_c !== 1'b1 || dout_c !== 32'hC3C3_C3C3) $display("FAIL b2b_2 got=%b/%h exp=1/c3c3c3c3", rvalid_c, dout_c); else passed++;
        tick();
        checks++; if (rvalid_c !== 1'b0 || dout_c !== 32'hC3C3_C3C3) $display("FAIL b2b_hold got=%b/%h exp=0/c3c3c3c3", rvalid_c, dout_c); else passed++;
    endtask

    task automatic test_no_forward();
        re = 1'b1; raddr = 4'd1;
        tick();
        re = 1'b0;
        we = 1'b1; waddr = 4'd1; din = 32'h5555_5555; be = 4'hF;
        tick();
        we = 1'b0; be = 4'h0;
        checks++; if (rvalid_c !== 1'b1 || dout_c !== 32'hA1A1_A1A1) $display("FAIL no_fwd got=%b/%h exp=1/a1a1a1a1", rvalid_c, dout_c); else passed++;
        do_read(4'd1);
        checks++; if (dout_a !== 32'h5555_5555) $display("FAIL no_fwd_wr got=%h exp=55555555", dout_a); else passed++;
    endtask

    task automatic test_narrow();
        be = 4'h0;
        we = 1'b1; waddr = 4'd3; din_d = 20'h12345; be_d = 3'b111;
        tick();
        din_d = 20'hFFFFF; be_d = 3'b100;
        tick();
        we = 1'b0; be_d = 3'b000;
        do_read(4'd3);
        checks++; if (dout_d !== 20'hF2345) $display("FAIL narrow_top got=%h exp=f2345", dout_d); else passed++;
        checks++; if (dout_a !== 32'hC3C3_C3C3) $display("FAIL narrow_a_untouched got=%h exp=c3c3c3c3", dout_a); else passed++;
        we = 1'b1; din_d = 20'h00000; be_d = 3'b001;
        tick();
        we = 1'b0; be_d = 3'b000;
        do_read(4'd3);
        checks++; if (dout_d !== 20'hF2300) $display("FAIL narrow_low got=%h exp=f2300", dout_d); else passed++;
    endtask

    task automatic test_reset_mid_init();
        int  n;
        logic rv_seen;
        do_write(4'd10, 32'hCAFE_F00D, 4'hF);
        do_read(4'd10);
        checks++; if (dout_a !== 32'hCAFE_F00D) $display("FAIL pre_rst_wr got=%h exp=cafef00d", dout_a); else passed++;
        // leave a read in flight in the two-stage pipe, then reset over it
        re = 1'b1; raddr = 4'd1;
        tick();
        re = 1'b0; rst = 1'b1;
        tick();
        checks++; if (rvalid_c !== 1'b0) $display("FAIL rst_drop_rvalid got=%b exp=0", rvalid_c); else passed++;
        rst = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        checks++; if (busy_a !== 1'b1) $display("FAIL mid_init_busy got=%b exp=1", busy_a); else passed++;
        rst = 1'b0;
        we = 1'b1; waddr = 4'd0; din = 32'hFFFF_FFFF; be = 4'hF;
        re = 1'b1; raddr = 4'd0;
        n = 0; rv_seen = 1'b0;
        while (busy_a && n < 100) begin
            if (rvalid_a) rv_seen = 1'b1;
            n++;
            tick();
        end
        we = 1'b0; re = 1'b0; be = 4'h0;
        checks++; if (n !== 16) $display("FAIL reclr_busy_cycles got=%0d exp=16", n); else passed++;
        checks++; if (rv_seen !== 1'b0) $display("FAIL reclr_rvalid got=%b exp=0", rv_seen); else passed++;
        do_read(4'd0);
        checks++; if (dout_a !== 32'h0) $display("FAIL reclr_addr0 got=%h exp=00000000", dout_a); else passed++;
        do_read(4'd10);
        checks++; if (dout_a !== 32'h0) $display("FAIL reclr_addr10 got=%h exp=00000000", dout_a); else passed++;
        do_read(4'd15);
        checks++; if (dout_a !== 32'h0) $display("FAIL reclr_addr15 got=%h exp=00000000", dout_a); else passed++;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_bypass();
        test_be_zero();
        test_back_to_back();
        test_no_forward();
        test_narrow();
        test_reset_mid_init();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/peripheral_spram_1r1w_pipe.md
PERIPHERAL_SPRAM_1R1W_PIPE -- requirements
Module: peripheral_spram_1r1w_pipe

Interface
REQ-001 SHALL have parameter ABITS, default 10: address width; depth is 2**ABITS words.
REQ-002 SHALL have parameter DBITS, default 32: data word width.
REQ-003 SHALL have parameter LBITS, default 8: write-lane width; NLANES = (DBITS+LBITS-1)/LBITS.
REQ-004 SHALL have parameter LATENCY, default 1: read latency in cycles, legal values 1 or 2.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = read-during-write returns new data, 0 = old data.
REQ-006 SHALL have parameter CLEAR, default 1: 1 = zero the whole array after reset.
REQ-007 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-009 SHALL have port busy_o  output  1  array clear in progress.
REQ-010 SHALL have port waddr_i  input  ABITS  write address.
REQ-011 SHALL have port din_i  input  DBITS  write data.
REQ-012 SHALL have port we_i  input  1  write enable.
REQ-013 SHALL have port be_i  input  NLANES  per-lane write enable.
REQ-014 SHALL have port raddr_i  input  ABITS  read address.
REQ-015 SHALL have port re_i  input  1  read request.
REQ-016 SHALL have port dout_o  output  DBITS  registered read data.
REQ-017 SHALL have port rvalid_o  output  1  dout_o holds data of a completed read this cycle.

Function
REQ-018 SHALL fail elaboration when LATENCY is not 1 or 2, or when LBITS < 1.
REQ-019 SHALL implement a two-state FSM: INIT and READY.
REQ-020 SHALL, with CLEAR=1, enter INIT on reset, write zero to addresses 0 .. 2**ABITS-1, one address per cycle, and move to READY the cycle after the last address is written.
REQ-021 SHALL, with CLEAR=0, enter READY on the first cycle rst_i is low.
REQ-022 SHALL hold busy_o = 1 exactly while in INIT.
REQ-023 SHALL ignore we_i and re_i in INIT: no array update, no rvalid_o.
REQ-024 SHALL, in READY, write lane k (bits k*LBITS upward) of mem[waddr_i] when we_i=1 and be_i[k]=1.
REQ-025 SHALL limit the top lane to bits DBITS-1 .. (NLANES-1)*LBITS when DBITS is not a multiple of LBITS.
REQ-026 SHALL, in READY, sample mem[raddr_i] on a cycle with re_i=1, and present it on dout_o with rvalid_o=1 exactly LATENCY cycles later.
REQ-027 SHALL pipeline rvalid_o as a delayed copy of the accepted re_i, accepting back-to-back reads every cycle.
REQ-028 SHALL hold dout_o at its last value when no read completes; rvalid_o = 0 in those cycles.
REQ-029 SHALL, for a read and write to the same address in the same cycle with BYPASS=1, return din_i for lanes with be_i set and old memory contents for the other lanes.
REQ-030 SHALL, for the same collision with BYPASS=0, return the entire old word.
REQ-031 SHALL, with LATENCY=2, not forward a write issued in the cycle after a read; the read returns data as sampled in its own cycle.
REQ-032 SHALL, with we_i=1 and be_i all zero, leave the array unchanged.

Reset
REQ-033 SHALL, while rst_i=1, drive dout_o = 0, rvalid_o = 0, flush the read pipeline, and load the clear counter with 0.
REQ-034 SHALL drive busy_o = 1 while rst_i=1 when CLEAR=1, and 0 when CLEAR=0.
REQ-035 SHALL, on reset asserted mid-INIT or mid-read, abandon the operation and restart per REQ-020/021; array contents are changed only by INIT clearing.

Verification
REQ-036 SHALL cover: CLEAR=1, ABITS=4, reset released -> busy_o high for exactly 16 cycles; then reads of addresses 0..15 return 0x00000000.
REQ-037 SHALL cover: LATENCY=1, write 0xDEADBEEF to address 3 with be=4'hF, then read address 3 -> dout_o=0xDEADBEEF with rvalid_o=1 one cycle after re_i.
REQ-038 SHALL cover: BYPASS=1, mem[5]=0x11223344, same-cycle write 0xAABBCCDD with be=4'b0101 and read of address 5 -> dout_o=0x11BB33DD; with BYPASS=0 -> 0x11223344.
REQ-039 SHALL cover: LATENCY=2, reads of addresses 1, 2, 3 on consecutive cycles -> three consecutive rvalid_o pulses starting 2 cycles later, with data in order.
REQ-040 SHALL cover: DBITS=20, LBITS=8, write 0xFFFFF with be=3'b100 -> only bits 19..16 change.
REQ-041 SHALL cover: rst_i asserted at INIT address 7 -> busy_o stays high, clearing restarts at 0, and the pending rvalid_o is dropped.
